// File: rtl/bus_ctrl_pkg.sv
// Shared definitions for the bus transfer controller: default sizes,
// operation encodings and the controller state enumeration.
package bus_ctrl_pkg;

  localparam int DEF_DW   = 16;
  localparam int DEF_NREG = 8;

  localparam logic [1:0] OP_MOV  = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_READ = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    LATCH,
    INCR,
    TURN
  } state_e;

endpackage

// File: rtl/onehot_dec.sv
// Index-to-one-hot decoder with an enable; an all-zero output when disabled.
module onehot_dec #(
  parameter int NREG = 8,
  parameter int SW   = 3
) (
  input  logic [SW-1:0]   idx_i,
  input  logic            en_i,
  output logic [NREG-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/bus_ctrl.sv
// Shared-bus transfer controller sequencing register-to-register moves, reads
// and increments; every output is registered from the next-state decode.
module bus_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter  int DW   = DEF_DW,
  parameter  int NREG = DEF_NREG,
  localparam int SW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            RST,
  input  logic            REQ,
  input  logic [1:0]      OP,
  input  logic [SW-1:0]   SRC,
  input  logic [SW-1:0]   DST,
  input  logic [DW-1:0]   BIN,
  output logic [NREG-1:0] LDBUS,
  output logic [NREG-1:0] WR,
  output logic [NREG-1:0] INC,
  output logic            BUSY,
  output logic            DONE,
  output logic            ERR,
  output logic [DW-1:0]   CAP
);

  state_e          state_q, state_d;
  logic [SW-1:0]   src_q, src_d;
  logic [SW-1:0]   dst_q, dst_d;
  logic [1:0]      op_q, op_d;
  logic            err_d;
  logic [NREG-1:0] ldbus_d, wr_d, inc_d;
  logic [NREG-1:0] ldbus_q, wr_q, inc_q;
  logic            busy_q, done_q, err_q;
  logic [DW-1:0]   cap_q;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    op_d    = op_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (REQ) begin
          case (OP)
            OP_MOV: begin
              if (SRC != DST) begin
                src_d   = SRC;
                dst_d   = DST;
                op_d    = OP;
                state_d = DRIVE;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_READ: begin
              src_d   = SRC;
              op_d    = OP;
              state_d = DRIVE;
            end
            OP_INC: begin
              dst_d   = DST;
              op_d    = OP;
              state_d = INCR;
            end
            OP_RSV: err_d = 1'b1;
          endcase
        end
      end
      DRIVE:   state_d = LATCH;
      LATCH:   state_d = TURN;
      INCR:    state_d = TURN;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the upcoming state so they line up with it once registered.
  onehot_dec #(.NREG(NREG), .SW(SW)) u_ld_dec (
    .idx_i    (src_d),
    .en_i     ((state_d == DRIVE) || (state_d == LATCH)),
    .onehot_o (ldbus_d)
  );

  onehot_dec #(.NREG(NREG), .SW(SW)) u_wr_dec (
    .idx_i    (dst_d),
    .en_i     ((state_d == LATCH) && (op_d == OP_MOV)),
    .onehot_o (wr_d)
  );

  onehot_dec #(.NREG(NREG), .SW(SW)) u_inc_dec (
    .idx_i    (dst_d),
    .en_i     (state_d == INCR),
    .onehot_o (inc_d)
  );

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      op_q    <= OP_MOV;
      ldbus_q <= '0;
      wr_q    <= '0;
      inc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      op_q    <= op_d;
      ldbus_q <= ldbus_d;
      wr_q    <= wr_d;
      inc_q   <= inc_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == TURN);
      err_q   <= err_d;
      // The bus has settled for a full cycle by the end of LATCH.
      if (state_q == LATCH) cap_q <= BIN;
    end
  end

  assign LDBUS = ldbus_q;
  assign WR    = wr_q;
  assign INC   = inc_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign ERR   = err_q;
  assign CAP   = cap_q;

endmodule

// File: tb/tb_bus_ctrl.sv
// Directed self-checking bench for bus_ctrl with a simple register-file bus
// model and continuous strobe-exclusivity checks on the falling edge.
module tb_bus_ctrl;

  logic        clk;
  logic        RST;
  logic        REQ;
  logic [1:0]  OP;
  logic [2:0]  SRC;
  logic [2:0]  DST;
  logic [15:0] BIN;
  logic [7:0]  LDBUS;
  logic [7:0]  WR;
  logic [7:0]  INC;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [15:0] CAP;

  int passCount  = 0;
  int checkCount = 0;
  bit monitorOn  = 1'b0;

  bus_ctrl dut (
    .clk   (clk),
    .RST   (RST),
    .REQ   (REQ),
    .OP    (OP),
    .SRC   (SRC),
    .DST   (DST),
    .BIN   (BIN),
    .LDBUS (LDBUS),
    .WR    (WR),
    .INC   (INC),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .ERR   (ERR),
    .CAP   (CAP)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registers 0, 1 and 2 drive distinct patterns; an undriven bus reads as junk.
  always_comb begin
    if (LDBUS[2])      BIN = 16'hA5C3;
    else if (LDBUS[1]) BIN = 16'h5A3C;
    else if (LDBUS[0]) BIN = 16'h0F0F;
    else               BIN = 16'hDEAD;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic req, input logic [1:0] op,
                               input logic [2:0] src, input logic [2:0] dst);
    REQ = req;
    OP  = op;
    SRC = src;
    DST = dst;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (monitorOn) begin
      checkOutput("ldbusOneHot", {31'd0, $onehot0(LDBUS)}, 32'd1);
      checkOutput("wrOneHot",    {31'd0, $onehot0(WR)},    32'd1);
      checkOutput("incOneHot",   {31'd0, $onehot0(INC)},   32'd1);
      checkOutput("wrIncOverlap", {24'd0, WR & INC},       32'd0);
    end
  end

  initial begin
    RST = 1'b1;
    applyStimulus(1'b0, 2'b00, 3'd0, 3'd0);
    step();
    step();
    checkOutput("rstLdbus", {24'd0, LDBUS}, 32'h0);
    checkOutput("rstWr",    {24'd0, WR},    32'h0);
    checkOutput("rstInc",   {24'd0, INC},   32'h0);
    checkOutput("rstFlags", {29'd0, BUSY, DONE, ERR}, 32'h0);
    checkOutput("rstCap",   {16'd0, CAP},   32'h0);
    monitorOn = 1'b1;
    RST = 1'b0;
    step();

    // MOV 2 -> 5; inputs scrambled after acceptance must not matter
    applyStimulus(1'b1, 2'b00, 3'd2, 3'd5);
    step();
    applyStimulus(1'b0, 2'b01, 3'd6, 3'd1);
    checkOutput("movDriveLd",   {24'd0, LDBUS}, 32'h04);
    checkOutput("movDriveWr",   {24'd0, WR},    32'h00);
    checkOutput("movDriveBusy", {31'd0, BUSY},  32'h1);
    checkOutput("movDriveDone", {31'd0, DONE},  32'h0);
    step();
    checkOutput("movLatchLd", {24'd0, LDBUS}, 32'h04);
    checkOutput("movLatchWr", {24'd0, WR},    32'h20);
    step();
    checkOutput("movTurnLd",   {24'd0, LDBUS}, 32'h00);
    checkOutput("movTurnWr",   {24'd0, WR},    32'h00);
    checkOutput("movTurnDone", {31'd0, DONE},  32'h1);
    checkOutput("movCap",      {16'd0, CAP},   32'hA5C3);
    step();
    checkOutput("movIdleDone", {31'd0, DONE}, 32'h0);
    checkOutput("movIdleBusy", {31'd0, BUSY}, 32'h0);

    // INC 7
    applyStimulus(1'b1, 2'b01, 3'd0, 3'd7);
    step();
    applyStimulus(1'b0, 2'b00, 3'd0, 3'd0);
    checkOutput("incIncr",   {24'd0, INC},   32'h80);
    checkOutput("incIncrLd", {24'd0, LDBUS}, 32'h00);
    checkOutput("incBusy",   {31'd0, BUSY},  32'h1);
    step();
    checkOutput("incTurnInc",  {24'd0, INC},   32'h00);
    checkOutput("incTurnLd",   {24'd0, LDBUS}, 32'h00);
    checkOutput("incTurnDone", {31'd0, DONE},  32'h1);
    step();
    checkOutput("incIdleDone", {31'd0, DONE}, 32'h0);

    // Rejected requests: MOV 3 -> 3 then reserved opcode
    applyStimulus(1'b1, 2'b00, 3'd3, 3'd3);
    step();
    applyStimulus(1'b1, 2'b11, 3'd3, 3'd3);
    checkOutput("errSameErr",  {31'd0, ERR},  32'h1);
    checkOutput("errSameBusy", {31'd0, BUSY}, 32'h0);
    checkOutput("errSameStrb", {8'd0, LDBUS, WR, INC}, 32'h0);
    step();
    applyStimulus(1'b0, 2'b00, 3'd0, 3'd0);
    checkOutput("errRsvErr",  {31'd0, ERR},  32'h1);
    checkOutput("errRsvBusy", {31'd0, BUSY}, 32'h0);
    checkOutput("errRsvStrb", {8'd0, LDBUS, WR, INC}, 32'h0);
    step();
    checkOutput("errClear", {31'd0, ERR}, 32'h0);

    // READ 1 with REQ held and a MOV 0 -> 6 presented while busy
    applyStimulus(1'b1, 2'b10, 3'd1, 3'd4);
    step();
    applyStimulus(1'b1, 2'b00, 3'd0, 3'd6);
    checkOutput("rdDriveLd", {24'd0, LDBUS}, 32'h02);
    checkOutput("rdDriveWr", {24'd0, WR},    32'h00);
    step();
    checkOutput("rdLatchLd", {24'd0, LDBUS}, 32'h02);
    checkOutput("rdLatchWr", {24'd0, WR},    32'h00);
    step();
    checkOutput("rdTurnDone", {31'd0, DONE},  32'h1);
    checkOutput("rdCap",      {16'd0, CAP},   32'h5A3C);
    checkOutput("rdTurnLd",   {24'd0, LDBUS}, 32'h00);
    step();
    checkOutput("b2bIdleBusy", {31'd0, BUSY},  32'h0);
    checkOutput("b2bIdleLd",   {24'd0, LDBUS}, 32'h00);
    step();
    applyStimulus(1'b0, 2'b00, 3'd0, 3'd0);
    checkOutput("b2bDriveLd",   {24'd0, LDBUS}, 32'h01);
    checkOutput("b2bDriveBusy", {31'd0, BUSY},  32'h1);
    step();
    checkOutput("b2bLatchWr", {24'd0, WR}, 32'h40);
    step();
    checkOutput("b2bTurnDone", {31'd0, DONE}, 32'h1);
    checkOutput("b2bCap",      {16'd0, CAP},  32'h0F0F);
    step();

    // Reset in DRIVE of MOV 0 -> 4, with REQ still asserted during reset
    applyStimulus(1'b1, 2'b00, 3'd0, 3'd4);
    step();
    checkOutput("abortDriveLd", {24'd0, LDBUS}, 32'h01);
    RST = 1'b1;
    step();
    checkOutput("abortStrb", {8'd0, LDBUS, WR, INC}, 32'h0);
    checkOutput("abortBusy", {31'd0, BUSY}, 32'h0);
    checkOutput("abortCap",  {16'd0, CAP},  32'h0);
    RST = 1'b0;
    applyStimulus(1'b0, 2'b00, 3'd0, 3'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("abortNoWr",   {24'd0, WR},   32'h0);
      checkOutput("abortNoDone", {31'd0, DONE}, 32'h0);
    end

    monitorOn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL timeout: observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
